// File: rtl/popcount_seq_pkg.sv
// popcount_seq_pkg
//   Shared definitions for the byte-serial popcount sequencer:
//   - state_e : sequencer state encoding (IDLE / RUN / DONE, 2 bits)
//   - BYTE_W  : width of one pass through the shared decoder
//   - clog2   : constant function used to size counters at elaboration
package popcount_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2; returns the number of bits needed to index 'value' items.
    function automatic int clog2(input int value);
        int ret;
        ret = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                ret = i + 1;
            end else begin
                ret = ret;
            end
        end
        return ret;
    endfunction

endpackage : popcount_seq_pkg

// File: rtl/Deco_Sum.sv
// Deco_Sum
//   Purely combinational 8-bit population-count decoder.
//   Ports:
//     Input  [7:0] : byte to count
//     Output [3:0] : number of set bits in Input (0..8)
module Deco_Sum (
    input  logic [7:0] Input,
    output logic [3:0] Output
);

    // Add up the eight bits; zero latency.
    always_comb begin
        Output = 4'd0;
        for (int i = 0; i < 8; i++) begin
            Output = Output + {3'd0, Input[i]};
        end
    end

endmodule : Deco_Sum

// File: rtl/popcount_seq.sv
// popcount_seq
//   Computes the population count of a DATA_W-bit word by streaming it one
//   byte per cycle through a single shared Deco_Sum decoder and accumulating
//   the per-byte results. start/ready/done handshake; the total is held on
//   count_o until the next completion.
//   Ports:
//     clk      : system clock, rising edge
//     rst      : asynchronous active-high reset
//     start_i  : begin a count (honoured only while ready_o=1)
//     data_i   : word to count, captured with an accepted start_i
//     ready_o  : can accept start_i (IDLE or DONE)
//     busy_o   : counting in progress (RUN)
//     done_o   : one-cycle pulse, count_o is new in this cycle
//     count_o  : last completed count
module popcount_seq
    import popcount_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [DATA_W-1:0]               data_i,
    output logic                            ready_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic [clog2(DATA_W + 1)-1:0]    count_o
);

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int CNT_W  = clog2(DATA_W + 1);
    // A single-byte word still needs a one-bit index register.
    localparam int IDX_W  = (NBYTES > 1) ? clog2(NBYTES) : 1;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    acc_q,   acc_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [3:0]          deco_out;
    logic                accept;
    logic                last_byte;

    Deco_Sum u_deco (
        .Input  (shift_q[BYTE_W-1:0]),
        .Output (deco_out)
    );

    assign accept    = ready_o & start_i;
    assign last_byte = (idx_q == IDX_W'(NBYTES - 1));

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_byte) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                // A start here chains straight into the next word.
                if (start_i) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, then consume one byte per RUN cycle.
    always_comb begin
        shift_d = shift_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        count_d = count_q;
        if (accept) begin
            shift_d = data_i;
            acc_d   = '0;
            idx_d   = '0;
        end else if (state_q == RUN) begin
            shift_d = shift_q >> BYTE_W;
            acc_d   = acc_q + CNT_W'(deco_out);
            idx_d   = idx_q + IDX_W'(1);
            if (last_byte) begin
                // Fold in the final byte directly so count_o is ready at DONE.
                count_d = acc_q + CNT_W'(deco_out);
            end else begin
                count_d = count_q;
            end
        end else begin
            shift_d = shift_q;
        end
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        ready_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
            end
            RUN: begin
                busy_o = 1'b1;
            end
            DONE: begin
                ready_o = 1'b1;
                done_o  = 1'b1;
            end
            default: begin
                ready_o = 1'b0;
            end
        endcase
    end

    assign count_o = count_q;

endmodule : popcount_seq

// File: tb/tb_popcount_seq.sv
module tb_popcount_seq;

    logic        clk;
    logic        rst;

    logic        start32;
    logic [31:0] data32;
    logic        ready32, busy32, done32;
    logic [5:0]  count32;

    logic        start8;
    logic [7:0]  data8;
    logic        ready8, busy8, done8;
    logic [3:0]  count8;

    logic        start64;
    logic [63:0] data64;
    logic        ready64, busy64, done64;
    logic [6:0]  count64;

    int checks;
    int errors;

    popcount_seq #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start32), .data_i(data32),
        .ready_o(ready32), .busy_o(busy32), .done_o(done32), .count_o(count32)
    );

    popcount_seq #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .start_i(start8), .data_i(data8),
        .ready_o(ready8), .busy_o(busy8), .done_o(done8), .count_o(count8)
    );

    popcount_seq #(.DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .start_i(start64), .data_i(data64),
        .ready_o(ready64), .busy_o(busy64), .done_o(done64), .count_o(count64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_pop(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        start32 = 1'b0; data32 = 32'd0;
        start8 = 1'b0;  data8 = 8'd0;
        start64 = 1'b0; data64 = 64'd0;
        repeat (2) @(negedge clk);
        checks++; if (ready32 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready32); end
        checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy32); end
        checks++; if (done32 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done32); end
        checks++; if (count32 !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count32); end
        checks++; if ({ready8, busy8, done8, count8} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin errors++; $display("FAIL reset_dut8: got %b%b%b/%0d expected 100/0", ready8, busy8, done8, count8); end
        checks++; if ({ready64, busy64, done64, count64} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin errors++; $display("FAIL reset_dut64: got %b%b%b/%0d expected 100/0", ready64, busy64, done64, count64); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Zero word: exact latency profile, busy in cycles 1..4, done at 5.
    task automatic test_zero();
        logic exp_busy, exp_done;
        start32 = 1'b1; data32 = 32'h0000_0000;
        @(posedge clk); #1 start32 = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            exp_busy = (cyc >= 1 && cyc <= 4);
            exp_done = (cyc == 5);
            checks++; if (busy32 !== exp_busy) begin errors++; $display("FAIL zero_busy c%0d: got %b expected %b", cyc, busy32, exp_busy); end
            checks++; if (done32 !== exp_done) begin errors++; $display("FAIL zero_done c%0d: got %b expected %b", cyc, done32, exp_done); end
            checks++; if (ready32 !== !exp_busy) begin errors++; $display("FAIL zero_ready c%0d: got %b expected %b", cyc, ready32, !exp_busy); end
            if (cyc == 5) begin
                checks++; if (count32 !== 6'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", count32); end
            end
        end
    endtask

    // All ones, then a sparse word; previous count held until new done.
    task automatic test_ones_then_sparse();
        logic [31:0] words [2];
        int          exp_cnt [2];
        int          prev;
        words[0] = 32'hFFFF_FFFF; exp_cnt[0] = 32;
        words[1] = 32'h8000_0001; exp_cnt[1] = 2;
        prev = 0;
        for (int w = 0; w < 2; w++) begin
            start32 = 1'b1; data32 = words[w];
            @(posedge clk); #1 start32 = 1'b0;
            for (int cyc = 1; cyc <= 5; cyc++) begin
                @(negedge clk);
                if (cyc < 5) begin
                    checks++; if (int'(count32) !== prev) begin errors++; $display("FAIL hold_count w%0d c%0d: got %0d expected %0d", w, cyc, count32, prev); end
                end else begin
                    checks++; if (done32 !== 1'b1) begin errors++; $display("FAIL ones_done w%0d: got %b expected 1", w, done32); end
                    checks++; if (int'(count32) !== exp_cnt[w]) begin errors++; $display("FAIL ones_count w%0d: got %0d expected %0d", w, count32, exp_cnt[w]); end
                end
            end
            prev = exp_cnt[w];
            @(negedge clk);
        end
    endtask

    // start held high: accepted at cycle 0 and again in DONE at cycle 5.
    task automatic test_back_to_back();
        logic exp_busy, exp_done;
        start32 = 1'b1; data32 = 32'h0F0F_00FF;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            exp_busy = (cyc != 5 && cyc != 10);
            exp_done = (cyc == 5 || cyc == 10);
            checks++; if (busy32 !== exp_busy) begin errors++; $display("FAIL b2b_busy c%0d: got %b expected %b", cyc, busy32, exp_busy); end
            checks++; if (done32 !== exp_done) begin errors++; $display("FAIL b2b_done c%0d: got %b expected %b", cyc, done32, exp_done); end
            if (exp_done) begin
                checks++; if (count32 !== 6'd16) begin errors++; $display("FAIL b2b_count c%0d: got %0d expected 16", cyc, count32); end
            end
            if (cyc == 10) start32 = 1'b0;
        end
        @(negedge clk);
        checks++; if ({ready32, busy32, done32} !== 3'b100) begin errors++; $display("FAIL b2b_idle: got %b expected 100", {ready32, busy32, done32}); end
    endtask

    // start while busy is ignored and its data not sampled.
    task automatic test_ignore_busy();
        start32 = 1'b1; data32 = 32'h1234_5678;
        @(posedge clk); #1 start32 = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin start32 = 1'b1; data32 = 32'hFFFF_FFFF; end
            if (cyc == 3) start32 = 1'b0;
            checks++; if (done32 !== (cyc == 5)) begin errors++; $display("FAIL ign_done c%0d: got %b expected %b", cyc, done32, (cyc == 5)); end
            if (cyc == 5) begin
                checks++; if (count32 !== 6'd13) begin errors++; $display("FAIL ign_count: got %0d expected 13", count32); end
            end
            if (cyc == 6) begin
                checks++; if (busy32 !== 1'b0) begin errors++; $display("FAIL ign_idle: got %b expected 0", busy32); end
            end
        end
    endtask

    // Asynchronous reset mid-RUN discards the result; then a clean recount.
    task automatic test_reset_mid_run();
        start32 = 1'b1; data32 = 32'hAAAA_AAAA;
        @(posedge clk); #1 start32 = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({ready32, busy32, done32} !== 3'b100) begin errors++; $display("FAIL arst_flags: got %b expected 100", {ready32, busy32, done32}); end
        checks++; if (count32 !== 6'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", count32); end
        @(negedge clk); rst = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            checks++; if (done32 !== 1'b0 || busy32 !== 1'b0) begin errors++; $display("FAIL arst_quiet c%0d: got done=%b busy=%b expected 0/0", cyc, done32, busy32); end
        end
        start32 = 1'b1; data32 = 32'hAAAA_AAAA;
        @(posedge clk); #1 start32 = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (done32 !== 1'b1) begin errors++; $display("FAIL arst_redo_done: got %b expected 1", done32); end
        checks++; if (count32 !== 6'd16) begin errors++; $display("FAIL arst_redo_count: got %0d expected 16", count32); end
    endtask

    // DATA_W=8: 1000 random bytes, done at cycle 2.
    task automatic test_sweep8();
        logic [7:0] v;
        int         exp_cnt;
        for (int w = 0; w < 1000; w++) begin
            v = 8'($urandom());
            exp_cnt = ref_pop({56'd0, v});
            start8 = 1'b1; data8 = v;
            @(posedge clk); #1 start8 = 1'b0;
            for (int cyc = 1; cyc <= 2; cyc++) begin
                @(negedge clk);
                checks++; if (done8 !== (cyc == 2)) begin errors++; $display("FAIL sw8_done w%0d c%0d: got %b expected %b", w, cyc, done8, (cyc == 2)); end
            end
            checks++; if (int'(count8) !== exp_cnt) begin errors++; $display("FAIL sw8_count w%0d data=%h: got %0d expected %0d", w, v, count8, exp_cnt); end
        end
    endtask

    // DATA_W=64: 1000 random words, done at cycle 9.
    task automatic test_sweep64();
        logic [63:0] v;
        int          exp_cnt;
        for (int w = 0; w < 1000; w++) begin
            v = {$urandom(), $urandom()};
            if (w == 0) v = 64'hFFFF_FFFF_FFFF_FFFF;
            exp_cnt = ref_pop(v);
            start64 = 1'b1; data64 = v;
            @(posedge clk); #1 start64 = 1'b0;
            for (int cyc = 1; cyc <= 9; cyc++) begin
                @(negedge clk);
                checks++; if (done64 !== (cyc == 9)) begin errors++; $display("FAIL sw64_done w%0d c%0d: got %b expected %b", w, cyc, done64, (cyc == 9)); end
            end
            checks++; if (int'(count64) !== exp_cnt) begin errors++; $display("FAIL sw64_count w%0d data=%h: got %0d expected %0d", w, v, count64, exp_cnt); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_zero();
        test_ones_then_sparse();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_run();
        test_sweep8();
        test_sweep64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_popcount_seq
